// File: rtl/altsquare_stream.sv
// Streaming integer square with optional per-frame sum of squares, valid/ready backpressure
// and LSB/MSB result alignment with saturation.
module altsquare_stream #(
    parameter int unsigned DATA_WIDTH       = 16,
    parameter int unsigned RESULT_WIDTH     = 32,
    parameter int unsigned PIPELINE         = 2,
    parameter string       REPRESENTATION   = "UNSIGNED",
    parameter string       RESULT_ALIGNMENT = "LSB",
    parameter int unsigned ACC_WIDTH        = 40
) (
    input  logic                    clock,
    input  logic                    sclr,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic                    in_mode,
    output logic                    in_ready,
    output logic [RESULT_WIDTH-1:0] result,
    output logic                    out_ovf,
    output logic                    out_valid,
    input  logic                    out_ready
);
    localparam int unsigned SqW      = 2 * DATA_WIDTH;
    localparam bit          IsSigned = (REPRESENTATION == "SIGNED");
    localparam bit          AlignMsb = (RESULT_ALIGNMENT == "MSB");

    typedef enum logic {StIdle, StAccum} state_e;

    state_e                  state_q, state_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic                    frame_ovf_q, frame_ovf_d;
    logic [RESULT_WIDTH-1:0] result_q, result_d;
    logic                    out_ovf_q, out_ovf_d;
    logic                    out_valid_q, out_valid_d;

    logic                    advance;
    logic [DATA_WIDTH-1:0]   mag;
    logic [SqW-1:0]          sq_in;
    logic                    exit_valid, exit_last, exit_mode;
    logic [SqW-1:0]          exit_sq;

    assign advance  = !(out_valid_q && !out_ready);
    assign in_ready = advance;

    // Negating -2^(W-1) yields 2^(W-1), which is exact as a W-bit unsigned magnitude.
    always_comb begin
        mag   = (IsSigned && data[DATA_WIDTH-1]) ? (~data + DATA_WIDTH'(1)) : data;
        sq_in = SqW'(mag) * SqW'(mag);
    end

    if (PIPELINE == 1) begin : g_comb
        assign exit_valid = in_valid;
        assign exit_last  = in_last;
        assign exit_mode  = in_mode;
        assign exit_sq    = sq_in;
    end else begin : g_pipe
        localparam int unsigned NStg = PIPELINE - 1;
        logic [NStg-1:0] vld_q, last_q, mode_q;
        logic [SqW-1:0]  sq_q [NStg];

        always_ff @(posedge clock) begin
            if (sclr) begin
                vld_q <= '0;
            end else if (advance) begin
                vld_q[0] <= in_valid;
                for (int i = 1; i < int'(NStg); i++) vld_q[i] <= vld_q[i-1];
            end
        end

        always_ff @(posedge clock) begin
            if (advance) begin
                sq_q[0]   <= sq_in;
                last_q[0] <= in_last;
                mode_q[0] <= in_mode;
                for (int i = 1; i < int'(NStg); i++) begin
                    sq_q[i]   <= sq_q[i-1];
                    last_q[i] <= last_q[i-1];
                    mode_q[i] <= mode_q[i-1];
                end
            end
        end

        assign exit_valid = vld_q[NStg-1];
        assign exit_last  = last_q[NStg-1];
        assign exit_mode  = mode_q[NStg-1];
        assign exit_sq    = sq_q[NStg-1];
    end

    // Frame accumulation; a frame's first item sees an empty accumulator.
    logic [ACC_WIDTH:0]   sum_wide;
    logic [ACC_WIDTH-1:0] sum_sat;
    logic                 sum_ovf;

    always_comb begin
        sum_wide = {1'b0, (state_q == StAccum) ? acc_q : '0} + (ACC_WIDTH + 1)'(exit_sq);
        sum_ovf  = sum_wide[ACC_WIDTH];
        sum_sat  = sum_ovf ? '1 : sum_wide[ACC_WIDTH-1:0];
    end

    logic [RESULT_WIDTH-1:0] res0, res1;
    logic                    ovf0, ovf1;

    if (RESULT_WIDTH >= SqW) begin : g_al0_ext
        always_comb begin
            res0            = '0;
            res0[SqW-1:0]   = exit_sq;
        end
        assign ovf0 = 1'b0;
    end else if (AlignMsb) begin : g_al0_msb
        assign res0 = exit_sq[SqW-1 -: RESULT_WIDTH];
        assign ovf0 = 1'b0;
    end else begin : g_al0_lsb
        assign ovf0 = |exit_sq[SqW-1:RESULT_WIDTH];
        assign res0 = ovf0 ? '1 : exit_sq[RESULT_WIDTH-1:0];
    end

    if (RESULT_WIDTH >= ACC_WIDTH) begin : g_al1_ext
        always_comb begin
            res1                  = '0;
            res1[ACC_WIDTH-1:0]   = sum_sat;
        end
        assign ovf1 = 1'b0;
    end else if (AlignMsb) begin : g_al1_msb
        assign res1 = sum_sat[ACC_WIDTH-1 -: RESULT_WIDTH];
        assign ovf1 = 1'b0;
    end else begin : g_al1_lsb
        assign ovf1 = |sum_sat[ACC_WIDTH-1:RESULT_WIDTH];
        assign res1 = ovf1 ? '1 : sum_sat[RESULT_WIDTH-1:0];
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        frame_ovf_d = frame_ovf_q;
        result_d    = result_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        if (advance) begin
            out_valid_d = 1'b0;
            if (exit_valid) begin
                if (state_q == StIdle && !exit_mode) begin
                    result_d    = res0;
                    out_ovf_d   = ovf0;
                    out_valid_d = 1'b1;
                end else if (exit_last) begin
                    result_d    = res1;
                    out_ovf_d   = ovf1 | frame_ovf_q | sum_ovf;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    frame_ovf_d = 1'b0;
                    state_d     = StIdle;
                end else begin
                    acc_d       = sum_sat;
                    frame_ovf_d = frame_ovf_q | sum_ovf;
                    state_d     = StAccum;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            frame_ovf_q <= 1'b0;
            result_q    <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            frame_ovf_q <= frame_ovf_d;
            result_q    <= result_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign out_ovf   = out_ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_altsquare_stream.sv
// Bench for altsquare_stream: two configurations, a frame-level reference model fed by accepted
// samples, a per-cycle output compare, and literal expectations for the directed scenarios.
module tb_altsquare_stream;
    typedef struct {
        longint unsigned r;
        bit              o;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sclr [2];
    logic [7:0]  din  [2];
    logic        iv   [2];
    logic        il   [2];
    logic        im   [2];
    logic        ordy [2];
    logic        ir_a, ov_a, ovf_a, ir_b, ov_b, ovf_b;
    logic [15:0] res_a;
    logic [7:0]  res_b;

    int   tests = 0;
    int   fails = 0;
    exp_t q_a[$], q_b[$], log_a[$], log_b[$];
    bit              in_frame [2];
    longint unsigned macc     [2];
    bit              msat     [2];

    // DUT a: signed 8-bit, 16-bit LSB result, 3 stages, 18-bit accumulator.
    altsquare_stream #(
        .DATA_WIDTH(8), .RESULT_WIDTH(16), .PIPELINE(3), .REPRESENTATION("SIGNED"),
        .RESULT_ALIGNMENT("LSB"), .ACC_WIDTH(18)
    ) dut_a (
        .clock(clk), .sclr(sclr[0]), .data(din[0]), .in_valid(iv[0]), .in_last(il[0]),
        .in_mode(im[0]), .in_ready(ir_a), .result(res_a), .out_ovf(ovf_a),
        .out_valid(ov_a), .out_ready(ordy[0])
    );

    // DUT b: unsigned 8-bit, 8-bit MSB result, 1 stage, 20-bit accumulator.
    altsquare_stream #(
        .DATA_WIDTH(8), .RESULT_WIDTH(8), .PIPELINE(1), .REPRESENTATION("UNSIGNED"),
        .RESULT_ALIGNMENT("MSB"), .ACC_WIDTH(20)
    ) dut_b (
        .clock(clk), .sclr(sclr[1]), .data(din[1]), .in_valid(iv[1]), .in_last(il[1]),
        .in_mode(im[1]), .in_ready(ir_b), .result(res_b), .out_ovf(ovf_b),
        .out_valid(ov_b), .out_ready(ordy[1])
    );

    function automatic void chk(string name, longint unsigned got, longint unsigned exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endfunction

    function automatic int qsize(int d);
        return (d == 0) ? q_a.size() : q_b.size();
    endfunction

    function automatic logic rdy(int d);
        return (d == 0) ? ir_a : ir_b;
    endfunction

    function automatic logic ovd(int d);
        return (d == 0) ? ov_a : ov_b;
    endfunction

    function automatic exp_t align(int d, longint unsigned v, int full, bit sat);
        exp_t e;
        int   rw = (d == 0) ? 16 : 8;
        e.o = sat;
        if (rw >= full) e.r = v;
        else if (d == 1) e.r = v >> (full - rw);
        else if ((v >> rw) != 0) begin
            e.r = (64'd1 << rw) - 1;
            e.o = 1'b1;
        end else e.r = v;
        return e;
    endfunction

    function automatic void push(int d, exp_t e);
        if (d == 0) q_a.push_back(e);
        else q_b.push_back(e);
    endfunction

    function automatic void model_accept(int d, logic [7:0] x, logic lst, logic md);
        longint unsigned mag, sq, accmax, sum;
        int              accw = (d == 0) ? 18 : 20;
        mag    = (d == 0 && x[7]) ? 64'd256 - 64'(x) : 64'(x);
        sq     = mag * mag;
        accmax = (64'd1 << accw) - 1;
        if (!in_frame[d] && !md) begin
            push(d, align(d, sq, 16, 1'b0));
        end else begin
            sum = (in_frame[d] ? macc[d] : 64'd0) + sq;
            if (sum > accmax) begin
                sum     = accmax;
                msat[d] = 1'b1;
            end
            if (lst) begin
                push(d, align(d, sum, accw, msat[d]));
                in_frame[d] = 1'b0;
                macc[d]     = 0;
                msat[d]     = 1'b0;
            end else begin
                in_frame[d] = 1'b1;
                macc[d]     = sum;
            end
        end
    endfunction

    function automatic void monitor(int d, logic rst, logic acc, logic [7:0] x, logic lst,
                                    logic md, logic ovld, logic ordy_v,
                                    longint unsigned r, logic o);
        exp_t e;
        if (rst) begin
            if (d == 0) q_a.delete();
            else q_b.delete();
            in_frame[d] = 1'b0;
            macc[d]     = 0;
            msat[d]     = 1'b0;
            return;
        end
        if (ovld) begin
            if (qsize(d) == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output dut%0d: got result %0d, expected no output", d, r);
            end else begin
                e = (d == 0) ? q_a[0] : q_b[0];
                chk($sformatf("dut%0d_result", d), r, e.r);
                chk($sformatf("dut%0d_ovf", d), 64'(o), 64'(e.o));
                if (ordy_v) begin
                    e.r = r;
                    e.o = o;
                    if (d == 0) begin
                        void'(q_a.pop_front());
                        log_a.push_back(e);
                    end else begin
                        void'(q_b.pop_front());
                        log_b.push_back(e);
                    end
                end
            end
        end
        if (acc) model_accept(d, x, lst, md);
    endfunction

    always @(negedge clk) begin
        monitor(0, sclr[0], iv[0] && ir_a, din[0], il[0], im[0], ov_a, ordy[0], 64'(res_a),
                ovf_a);
        monitor(1, sclr[1], iv[1] && ir_b, din[1], il[1], im[1], ov_b, ordy[1], 64'(res_b),
                ovf_b);
    end

    function automatic void chk_log(int d, int idx, longint unsigned r, bit o);
        int   sz = (d == 0) ? log_a.size() : log_b.size();
        exp_t e;
        if (idx >= sz) begin
            tests++;
            fails++;
            $display("FAIL log_missing dut%0d: got %0d outputs, expected at least %0d", d, sz,
                     idx + 1);
            return;
        end
        e = (d == 0) ? log_a[idx] : log_b[idx];
        chk($sformatf("log%0d_%0d_result", d, idx), e.r, r);
        chk($sformatf("log%0d_%0d_ovf", d, idx), 64'(e.o), 64'(o));
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int d, input logic [7:0] x, input logic lst, input logic md);
        int n = 0;
        din[d] = x;
        il[d]  = lst;
        im[d]  = md;
        iv[d]  = 1'b1;
        @(negedge clk);
        while (!rdy(d) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 64'(n), 0);
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n = 0;
        while (qsize(d) != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("drain%0d_pending", d), 64'(qsize(d)), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Accepted in cycle t, out_valid first seen in cycle t+PIPELINE.
    task automatic latency(input int d, input logic [7:0] x, input int exp_k);
        int k = 0;
        send(d, x, 1'b0, 1'b0);
        while (!ovd(d) && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk($sformatf("latency%0d", d), 64'(k), 64'(exp_k));
    endtask

    bit rnd_done;

    task automatic random_phase(input int d, input int n);
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    int sel = int'($urandom_range(0, 63));
                    if (sel == 0) begin
                        sclr[d] = 1'b1;
                        @(posedge clk);
                        #1;
                        sclr[d] = 1'b0;
                    end else if (sel < 16) begin
                        @(posedge clk);
                        #1;
                    end else begin
                        send(d, 8'($urandom), $urandom_range(0, 5) == 0,
                             $urandom_range(0, 1) == 1);
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    ordy[d] = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ordy[d] = 1'b1;
        drain(d);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected the run to complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            sclr[d] = 1'b1;
            din[d]  = '0;
            iv[d]   = 1'b0;
            il[d]   = 1'b0;
            im[d]   = 1'b0;
            ordy[d] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        sclr[0] = 1'b0;
        sclr[1] = 1'b0;
        chk("rst_result_a", 64'(res_a), 0);
        chk("rst_valid_a", 64'(ov_a), 0);
        chk("rst_ovf_a", 64'(ovf_a), 0);
        chk("rst_ready_a", 64'(ir_a), 1);
        chk("rst_result_b", 64'(res_b), 0);
        chk("rst_valid_b", 64'(ov_b), 0);

        // -128 squares exactly; -1 squares to 1.
        latency(0, 8'h80, 2);
        drain(0);
        send(0, 8'hFF, 1'b0, 1'b0);
        drain(0);
        chk_log(0, 0, 16384, 1'b0);
        chk_log(0, 1, 1, 1'b0);

        // Back-to-back with a two-cycle stall while 4 is presented.
        log_a.delete();
        fork
            begin
                send(0, 8'd1, 1'b0, 1'b0);
                send(0, 8'd2, 1'b0, 1'b0);
                send(0, 8'd3, 1'b0, 1'b0);
                send(0, 8'd5, 1'b0, 1'b0);
            end
            begin
                int n = 0;
                while (!(ov_a && res_a == 16'd4) && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("stall_target_seen", 64'(n < 50), 1);
                ordy[0] = 1'b0;
                @(negedge clk);
                chk("in_ready_stall1", 64'(ir_a), 0);
                @(negedge clk);
                chk("in_ready_stall2", 64'(ir_a), 0);
                @(posedge clk);
                #1;
                ordy[0] = 1'b1;
            end
        join
        drain(0);
        chk("stall_count", 64'(log_a.size()), 4);
        chk_log(0, 0, 1, 1'b0);
        chk_log(0, 1, 4, 1'b0);
        chk_log(0, 2, 9, 1'b0);
        chk_log(0, 3, 25, 1'b0);

        // Frame 3,4,-12 then single mode-0 sample 7.
        log_a.delete();
        send(0, 8'd3, 1'b0, 1'b1);
        send(0, 8'd4, 1'b0, 1'b1);
        send(0, 8'hF4, 1'b1, 1'b1);
        send(0, 8'd7, 1'b0, 1'b0);
        drain(0);
        chk("frame_count", 64'(log_a.size()), 2);
        chk_log(0, 0, 169, 1'b0);
        chk_log(0, 1, 49, 1'b0);

        // Alignment saturation, accumulator saturation, then a clean frame.
        log_a.delete();
        for (int i = 0; i < 5; i++) send(0, 8'd127, i == 4, 1'b1);
        for (int i = 0; i < 17; i++) send(0, 8'h80, i == 16, 1'b1);
        send(0, 8'd2, 1'b0, 1'b1);
        send(0, 8'd2, 1'b1, 1'b1);
        drain(0);
        chk_log(0, 0, 65535, 1'b1);
        chk_log(0, 1, 65535, 1'b1);
        chk_log(0, 2, 8, 1'b0);

        // Reset mid-frame discards the partial frame.
        log_a.delete();
        send(0, 8'd10, 1'b0, 1'b1);
        send(0, 8'd10, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        sclr[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("sclr_result", 64'(res_a), 0);
        chk("sclr_valid", 64'(ov_a), 0);
        chk("sclr_ovf", 64'(ovf_a), 0);
        sclr[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("post_sclr_result", 64'(res_a), 0);
        chk("post_sclr_ready", 64'(ir_a), 1);
        send(0, 8'd2, 1'b0, 1'b1);
        send(0, 8'd2, 1'b1, 1'b1);
        drain(0);
        chk("sclr_frame_count", 64'(log_a.size()), 1);
        chk_log(0, 0, 8, 1'b0);

        // MSB alignment, single-stage latency.
        log_b.delete();
        latency(1, 8'd255, 0);
        drain(1);
        chk_log(1, 0, 8'hFE, 1'b0);
        send(1, 8'd255, 1'b0, 1'b1);
        send(1, 8'd255, 1'b1, 1'b1);
        drain(1);
        chk_log(1, 1, 31, 1'b0);

        random_phase(0, 400);
        random_phase(1, 400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/altsquare_stream.md
Name: altsquare_stream

Overview:
- Streaming, parameterised successor to the integer-square megafunction.
- Squares signed or unsigned samples through a configurable pipeline with valid/ready backpressure.
- Optional sum-of-squares (energy) mode over frames delimited by `in_last`.
- Result alignment (LSB/MSB) with saturation and an overflow flag. Sits between sample sources (ADC/DSP front end) and power/energy consumers.

Parameters:
- DATA_WIDTH, 16: input sample width, >=1.
- RESULT_WIDTH, 32: output width, >=1.
- PIPELINE, 2: stages from accept to `out_valid`, >=1; the last stage is the output register.
- REPRESENTATION, "UNSIGNED": "UNSIGNED" or "SIGNED" interpretation of `data`.
- RESULT_ALIGNMENT, "LSB": "LSB" or "MSB" selection of the full-precision value.
- ACC_WIDTH, 40: accumulator width for mode 1, must be >= 2*DATA_WIDTH.

Ports:
- clock, input, 1: single clock, rising edge.
- sclr, input, 1: synchronous clear, active-high.
- data, input, DATA_WIDTH: sample.
- in_valid, input, 1: sample valid.
- in_last, input, 1: last sample of frame (mode 1 only).
- in_mode, input, 1: 0 = per-sample square, 1 = frame sum of squares; sampled at frame start.
- in_ready, output, 1: block accepts a sample this cycle.
- result, output, RESULT_WIDTH: aligned result.
- out_ovf, output, 1: result saturated.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts result.

Behaviour:
- Clock and reset: one clock, `clock`; reset `sclr` is synchronous and active-high.
- Reset values:
  - `sclr` high at a clock edge clears all stage valid bits, the accumulator, frame state and `out_ovf`.
  - After reset: `result`=0, `out_valid`=0, `out_ovf`=0, `in_ready`=1.
  - Reset mid-frame discards the partial frame. No output is ever produced for it.
- Handshake:
  - A transfer occurs when valid and ready are both 1.
  - `advance` = !(out_valid && !out_ready). `in_ready` = `advance` (combinational).
  - When `advance`=0, all stages hold, including data, valid, last and mode.
- Latency:
  - Mode 0: a result appears `out_valid`=1 exactly PIPELINE cycles after acceptance when there is no stall. Stalls add cycle-for-cycle.
  - Full throughput: one sample per cycle.
- Magnitude and square:
  - SIGNED with MSB set: magnitude = two's-complement negation, computed in DATA_WIDTH+1 bits so that -2^(DATA_WIDTH-1) is exact.
  - Square width is 2*DATA_WIDTH, unsigned. It is computed in stage 1 (combinational into the output register when PIPELINE=1).
- Frame FSM, states IDLE and ACCUM, evaluated when an item exits stage PIPELINE-1 with `advance`=1:
  - IDLE, mode=0: load output register with align(square); `out_valid`=1; stay IDLE.
  - IDLE, mode=1, last=0: acc = square; go to ACCUM; no output.
  - IDLE, mode=1, last=1: output align(square) with acc width semantics; stay IDLE.
  - ACCUM, last=0: acc = sat(acc + square).
  - ACCUM, last=1: output align(sat(acc + square)); clear acc; go IDLE.
  - In ACCUM, the item's `in_mode` is ignored; mode is latched at frame start.
- Accumulator: saturates at 2^ACC_WIDTH-1 and sets a sticky frame-overflow bit. That bit ORs into `out_ovf` of the frame result and is cleared when the frame completes.
- Output register: when loaded without a valid new output while `out_ready`=1, `out_valid` drops to 0 next cycle.
- Alignment, with FULL = 2*DATA_WIDTH (mode 0) or ACC_WIDTH (mode 1):
  - RESULT_WIDTH >= FULL: zero-extend; `out_ovf` only from accumulator saturation.
  - LSB, RESULT_WIDTH < FULL: if any discarded upper bit is 1, `result` = all-ones and `out_ovf`=1; otherwise low bits, `out_ovf`=0.
  - MSB, RESULT_WIDTH < FULL: `result` = FULL[FULL-1 -: RESULT_WIDTH], truncated with no rounding; `out_ovf` only from accumulator saturation.
- Simultaneous events:
  - Input accept and output drain in the same cycle are both legal.
  - `sclr` overrides all handshakes.
  - `in_last` is ignored in mode 0.

Test Plan:
Parameters for tests 1–5: DATA_WIDTH=8, SIGNED, RESULT_WIDTH=16, LSB, PIPELINE=3, ACC_WIDTH=18.
1. Mode 0, data=-128 accepted at cycle t -> `out_valid` at t+3, `result`=16384 (0x4000), `out_ovf`=0. Data=-1 -> 1.
2. Mode 0, back-to-back 1,2,3,5 with `out_ready` low for 2 cycles while result 4 is presented -> `in_ready` low during the stall; outputs exactly 1,4,9,25 in order, none lost or duplicated.
3. Mode 1 frame 3,4,-12 (last on -12), then mode 0 sample 7 -> single frame output 169, then 49; no intermediate outputs.
4. Mode 1 frame of five 127s -> sum 80645 > 65535 -> `result`=65535, `out_ovf`=1. Frame of seventeen -128s -> accumulator saturates at 262143, `result`=65535, `out_ovf`=1. The following frame of 2,2(last) -> 8, `out_ovf`=0.
5. Mode 1 frame 10,10, then `sclr` pulse, then frame 2,2(last) -> no output for the aborted frame; output 8. All outputs are 0 during and immediately after reset.
6. DATA_WIDTH=8, UNSIGNED, RESULT_WIDTH=8, MSB, data=255 -> 65025 (0xFE01) -> `result`=0xFE, `out_ovf`=0. With PIPELINE=1, latency is 1 cycle.
